prefetch_buffer: RTL and testbench

Parametrised instruction prefetch unit for the RV32IC fetch stage. It sits between the instruction memory port and decode.
- Keeps up to NUM_OUTSTANDING word requests in flight.
- Buffers returned words in a DEPTH-entry FIFO.
- Realigns 16/32-bit instructions across word boundaries and presents one instruction per valid/ready handshake.
- On a branch, discards buffered data and in-flight responses.

---
 rtl/prefetch_pkg.sv | 17 +
 rtl/prefetch_fifo.sv | 74 +++++++
 rtl/prefetch_buffer.sv | 168 ++++++++++++++++
 tb/tb_prefetch_buffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the RV32IC instruction prefetch unit.
package prefetch_pkg;

    // Counter width sized for the largest supported NUM_OUTSTANDING.
    localparam int MAX_OUTSTANDING = 4;
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } fifo_entry_t;

    function automatic logic is_compressed(input logic [1:0] lsb);
        return lsb != 2'b11;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Shift-register FIFO of fetched words; entry 0 is always the oldest word.
// Zero latency from push to head; flush takes priority over a same-cycle push.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  fifo_entry_t                entry_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fifo_entry_t                head0_o,
    output fifo_entry_t                head1_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);

    fifo_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           wr_idx;
    logic                    do_pop;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != '0);
        wr_idx  = do_pop ? count_q - CW'(1) : count_q;
        if (flush_i) begin
            mem_d   = '0;
            count_d = '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
                // Vacated slots read as zero so a missing w1 never carries stale err.
                mem_d[DEPTH-1] = '0;
            end
            if (push_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(wr_idx)) begin
                        mem_d[i] = entry_i;
                    end
                end
            end
            unique case ({push_i, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign head0_o = mem_q[0];
    assign head1_o = mem_q[1];
    assign count_o = count_q;

    push_full_a: assert property (@(posedge clk) disable iff (!rstn)
        !(push_i && !pop_i && !flush_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/prefetch_buffer.sv
// RV32IC prefetch: bounded in-flight word requests, word FIFO, 16/32-bit realigner.
// Output is combinational from FIFO head; branches flush and drop in-flight responses.
module prefetch_buffer
    import prefetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET        = 32'h0,
    parameter int          DEPTH           = 3,
    parameter int          NUM_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_en_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] addr_o,
    output logic        is_compressed_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i
);

    localparam int FCW = $clog2(DEPTH + 1);

    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic [31:0]      out_pc_q, out_pc_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic             req_pend_q, req_pend_d;
    logic             req_stale_q, req_stale_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic [FCW-1:0]   fifo_count;
    fifo_entry_t      w0, w1;
    fifo_entry_t      push_entry;
    logic             fifo_push, fifo_pop;
    logic             new_req, gnt, pend_after;

    logic             out_vld, pop_word, accept, instr_comp, instr_err;
    logic [31:0]      instr;
    logic             unused_w1_hi;

    // A raised request is held (address included) until granted.
    assign new_req      = fetch_en_i
                       && (32'(outst_q) < NUM_OUTSTANDING)
                       && (32'(fifo_count) + 32'(outst_q) < DEPTH);
    assign instr_req_o  = req_pend_q || new_req;
    assign instr_addr_o = req_pend_q ? req_addr_q : fetch_addr_q;
    assign gnt          = instr_req_o && instr_gnt_i;
    assign pend_after   = instr_req_o && !instr_gnt_i;

    always_comb begin
        req_pend_d  = pend_after;
        req_addr_d  = instr_addr_o;
        req_stale_d = pend_after && (branch_i || (req_pend_q && req_stale_q));

        fetch_addr_d = fetch_addr_q;
        if (branch_i) begin
            fetch_addr_d = {branch_addr_i[31:2], 2'b00};
        end else if (gnt && !(req_pend_q && req_stale_q)) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
        end

        unique case ({gnt, instr_rvalid_i})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        discard_d = discard_q;
        if (instr_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end
        // A still-pending request will be granted later, so its response is pre-counted.
        if (branch_i) begin
            discard_d = outst_d + CNT_W'(pend_after);
        end
    end

    assign fifo_push  = instr_rvalid_i && (discard_q == '0);
    assign push_entry = '{err: instr_err_i, data: instr_rdata_i};

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fifo_push),
        .entry_i (push_entry),
        .pop_i   (fifo_pop),
        .flush_i (branch_i),
        .head0_o (w0),
        .head1_o (w1),
        .count_o (fifo_count)
    );

    always_comb begin
        instr     = w0.data;
        instr_err = w0.err;
        out_vld   = (fifo_count != '0);
        pop_word  = 1'b0;
        if (!out_pc_q[1]) begin
            if (is_compressed(w0.data[1:0])) begin
                instr = {16'h0, w0.data[15:0]};
            end else begin
                pop_word = 1'b1;
            end
        end else if (is_compressed(w0.data[17:16])) begin
            instr    = {16'h0, w0.data[31:16]};
            pop_word = 1'b1;
        end else begin
            // Spanning: an errored w0 is reported without waiting for w1.
            instr     = {w1.data[15:0], w0.data[31:16]};
            instr_err = w0.err || ((fifo_count > FCW'(1)) && w1.err);
            out_vld   = (fifo_count > FCW'(1)) || ((fifo_count != '0) && w0.err);
            pop_word  = 1'b1;
        end
    end

    assign instr_comp   = is_compressed(instr[1:0]);
    assign accept       = out_vld && ready_i && !branch_i;
    assign fifo_pop     = accept && pop_word;
    assign unused_w1_hi = ^w1.data[31:16];

    always_comb begin
        out_pc_d = out_pc_q;
        if (branch_i) begin
            out_pc_d = branch_addr_i;
        end else if (accept) begin
            out_pc_d = out_pc_q + (instr_comp ? 32'd2 : 32'd4);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_addr_q <= PC_RESET & ~32'h3;
            out_pc_q     <= PC_RESET;
            req_addr_q   <= '0;
            req_pend_q   <= 1'b0;
            req_stale_q  <= 1'b0;
            outst_q      <= '0;
            discard_q    <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            out_pc_q     <= out_pc_d;
            req_addr_q   <= req_addr_d;
            req_pend_q   <= req_pend_d;
            req_stale_q  <= req_stale_d;
            outst_q      <= outst_d;
            discard_q    <= discard_d;
        end
    end

    assign valid_o         = out_vld;
    assign instr_o         = out_vld ? instr : 32'h0;
    assign addr_o          = out_vld ? out_pc_q : 32'h0;
    assign err_o           = out_vld && instr_err;
    assign is_compressed_o = out_vld && instr_comp;
    assign busy_o          = (outst_q != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed bench for prefetch_buffer: memory model in a negedge process, expected-instruction scoreboard.
module tb_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fetch_en_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        is_compressed_o;
    logic        err_o;
    logic        busy_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i    = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i  = 32'h0;
    logic        instr_err_i    = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    exp_t        exp_q[$];
    resp_t       resp_q[$];
    logic [31:0] grant_log[$];
    resp_t       mem_r;
    bit          gnt_en  = 1'b1;
    bit          resp_en = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    prefetch_buffer #(
        .PC_RESET        (32'h100),
        .DEPTH           (3),
        .NUM_OUTSTANDING (2)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .fetch_en_i      (fetch_en_i),
        .branch_i        (branch_i),
        .branch_addr_i   (branch_addr_i),
        .ready_i         (ready_i),
        .valid_o         (valid_o),
        .instr_o         (instr_o),
        .addr_o          (addr_o),
        .is_compressed_o (is_compressed_o),
        .err_o           (err_o),
        .busy_o          (busy_o),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .instr_err_i     (instr_err_i)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h200: return 32'h00130001;
            32'h204: return 32'h00010000;
            32'h2FC: return 32'h00030001;
            32'h400: return 32'h00A70013;
            32'h700: return 32'h00000001;
            default: return 32'h00000013;
        endcase
    endfunction

    // Zero-wait memory: grant in the request cycle, data one cycle later, in order.
    always @(negedge clk) begin
        if (!rstn) begin
            instr_gnt_i    = 1'b0;
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = 32'h0;
            instr_err_i    = 1'b0;
            resp_q.delete();
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = 32'h0;
            instr_err_i    = 1'b0;
            if (resp_en && resp_q.size() > 0) begin
                mem_r          = resp_q.pop_front();
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem_r.data;
                instr_err_i    = mem_r.err;
            end
            instr_gnt_i = gnt_en && instr_req_o;
            if (instr_gnt_i) begin
                grant_log.push_back(instr_addr_o);
                resp_q.push_back('{data: mem_word(instr_addr_o), err: (instr_addr_o == 32'h300)});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_branch(input logic [31:0] a);
        branch_addr_i = a;
        branch_i      = 1'b1;
        step();
        branch_i      = 1'b0;
    endtask

    task automatic expect_instr(input logic [31:0] a, input logic [31:0] ins, input logic e);
        exp_q.push_back('{addr: a, instr: ins, err: e});
    endtask

    // Accept exactly n instructions, comparing each against the scoreboard head.
    task automatic consume(input int n);
        int   got;
        exp_t e;
        got     = 0;
        ready_i = 1'b1;
        for (int cyc = 0; cyc < 300 && got < n; cyc++) begin
            @(negedge clk);
            if (valid_o && ready_i && !branch_i) begin
                got++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL unexpected_instr: observed addr %h expected none", addr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("addr_o", addr_o, e.addr);
                    check("instr_o", instr_o, e.instr);
                    check("err_o", 32'(err_o), 32'(e.err));
                    check("is_compressed_o", 32'(is_compressed_o), 32'(e.instr[1:0] != 2'b11));
                end
            end
            @(posedge clk);
            #1;
        end
        ready_i = 1'b0;
        check("consume_count", got, n);
    endtask

    function automatic logic [31:0] grant_at(input int idx);
        return (grant_log.size() > idx) ? grant_log[idx] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int g0;
        int n5;
        rstn          = 1'b0;
        fetch_en_i    = 1'b0;
        branch_i      = 1'b0;
        branch_addr_i = 32'h0;
        ready_i       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_o", 32'(valid_o), 32'h0);
        check("rst_instr_req_o", 32'(instr_req_o), 32'h0);
        check("rst_busy_o", 32'(busy_o), 32'h0);
        check("rst_err_o", 32'(err_o), 32'h0);
        check("rst_is_compressed_o", 32'(is_compressed_o), 32'h0);
        check("rst_instr_o", instr_o, 32'h0);
        check("rst_addr_o", addr_o, 32'h0);

        // Reset fetch with decode stalled: exactly DEPTH words requested.
        rstn       = 1'b1;
        fetch_en_i = 1'b1;
        repeat (8) step();
        check("fill_grants", grant_log.size(), 3);
        check("grant0", grant_at(0), 32'h100);
        check("grant1", grant_at(1), 32'h104);
        check("grant2", grant_at(2), 32'h108);
        check("fill_no_req", 32'(instr_req_o), 32'h0);
        check("fill_busy", 32'(busy_o), 32'h1);
        for (int i = 0; i < 4; i++) expect_instr(32'h100 + 32'(4 * i), 32'h13, 1'b0);
        consume(4);
        check("grant3", grant_at(3), 32'h10C);

        // Compressed and spanning instructions.
        do_branch(32'h200);
        expect_instr(32'h200, 32'h00000001, 1'b0);
        expect_instr(32'h202, 32'h00000013, 1'b0);
        expect_instr(32'h206, 32'h00000001, 1'b0);
        expect_instr(32'h208, 32'h00000013, 1'b0);
        consume(4);

        // Backpressure after a branch, then in-order drain.
        g0 = grant_log.size();
        do_branch(32'h500);
        repeat (10) step();
        n5 = 0;
        for (int i = g0; i < grant_log.size(); i++)
            if (grant_log[i] >= 32'h500 && grant_log[i] < 32'h600) n5++;
        check("bp_grants", n5, 3);
        check("bp_no_req", 32'(instr_req_o), 32'h0);
        for (int i = 0; i < 4; i++) expect_instr(32'h500 + 32'(4 * i), 32'h13, 1'b0);
        consume(4);

        // Two responses in flight across a branch to an unaligned target.
        resp_en = 1'b0;
        do_branch(32'h600);
        repeat (5) step();
        check("inflight_no_req", 32'(instr_req_o), 32'h0);
        check("inflight_valid", 32'(valid_o), 32'h0);
        g0 = grant_log.size();
        do_branch(32'h402);
        resp_en = 1'b1;
        repeat (6) step();
        check("grant_after_branch", grant_at(g0), 32'h400);
        expect_instr(32'h402, 32'h001300A7, 1'b0);
        expect_instr(32'h406, 32'h00000000, 1'b0);
        expect_instr(32'h408, 32'h00000013, 1'b0);
        consume(3);

        // Grant stall with a branch in the middle of the pending request.
        repeat (8) step();
        gnt_en = 1'b0;
        do_branch(32'h700);
        step();
        check("stall_req_a", 32'(instr_req_o), 32'h1);
        check("stall_addr_a", instr_addr_o, 32'h700);
        do_branch(32'h800);
        check("stall_req_b", 32'(instr_req_o), 32'h1);
        check("stall_addr_b", instr_addr_o, 32'h700);
        step();
        check("stall_addr_c", instr_addr_o, 32'h700);
        g0 = grant_log.size();
        gnt_en = 1'b1;
        repeat (4) step();
        check("stall_grant0", grant_at(g0), 32'h700);
        check("stall_grant1", grant_at(g0 + 1), 32'h800);
        expect_instr(32'h800, 32'h13, 1'b0);
        expect_instr(32'h804, 32'h13, 1'b0);
        consume(2);

        // Bus errors: spanning into an errored word, then aligned at it.
        do_branch(32'h2FC);
        expect_instr(32'h2FC, 32'h00000001, 1'b0);
        expect_instr(32'h2FE, 32'h00130003, 1'b1);
        expect_instr(32'h302, 32'h00000000, 1'b1);
        expect_instr(32'h304, 32'h00000013, 1'b0);
        consume(4);
        do_branch(32'h300);
        expect_instr(32'h300, 32'h13, 1'b1);
        expect_instr(32'h304, 32'h13, 1'b0);
        consume(2);

        // Fetch disabled and flushed: unit goes idle.
        fetch_en_i = 1'b0;
        do_branch(32'h900);
        repeat (10) step();
        check("idle_busy", 32'(busy_o), 32'h0);
        check("idle_valid", 32'(valid_o), 32'h0);
        check("idle_req", 32'(instr_req_o), 32'h0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule
